// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises one WORD_W-bit word as WORD_W/DATA_BITS back-to-back
// UART frames, least-significant byte first, behind a valid/ready handshake.
// The macro UART_TX_PARITY_EN inserts a parity bit after the data bits; when it
// is not defined there is no parity state and PARITY_ODD has no effect.
module uart_word_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              txd,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NBYTES = WORD_W / DATA_BITS;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    // Elaboration-time parameter sanity checks
    if (CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_word_tx: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_word_tx: DATA_BITS must be 5..9");
    end
    if (WORD_W % DATA_BITS != 0 || WORD_W < DATA_BITS) begin : g_bad_word_w
        $error("uart_word_tx: WORD_W must be a multiple of DATA_BITS");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_word_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_word_tx: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [BYTE_W-1:0]   byte_q, byte_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic                txd_d, busy_d, done_d;

    logic [DATA_BITS-1:0] cur_byte;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 last_byte;

    // Current byte always sits in the low bits of the shift register
    assign cur_byte  = shreg_q[DATA_BITS-1:0];
    assign bit_end   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_q == BIT_W'(DATA_BITS - 1));
    assign last_stop = (bit_q == BIT_W'(STOP_BITS - 1));
    assign last_byte = (byte_q == BYTE_W'(NBYTES - 1));
    assign s_ready   = (state_q == S_IDLE);

    // State, counters, shift register and registered line outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            txd     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            txd     <= txd_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, counter and next-output logic
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        txd_d   = txd;
        busy_d  = busy;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (s_valid) begin
                    state_d = S_START;
                    shreg_d = s_data;
                    txd_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = cur_byte[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (last_data) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = (^cur_byte) ^ 1'(PARITY_ODD);
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        txd_d = cur_byte[bit_q + BIT_W'(1)];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (last_stop) begin
                        bit_d = '0;
                        if (last_byte) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            txd_d   = 1'b1;
                        end else begin
                            // Next start bit follows the stop bit directly
                            state_d = S_START;
                            byte_d  = byte_q + BYTE_W'(1);
                            shreg_d = shreg_q >> DATA_BITS;
                            txd_d   = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed, table-driven bench for uart_word_tx with three
// instances (8N1 even, 7-bit/2-stop 14-bit word, 8-bit odd parity).
module tb_uart_word_tx;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    typedef struct {
        int              sel;
        logic [31:0]     word;
        int              nbytes;
        int              dbits;
        int              sbits;
        logic [3:0][8:0] exp_byte;
        logic [3:0]      exp_par;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        valid_a, valid_b, valid_c;
    logic        ready_a, ready_b, ready_c;
    logic        txd_a, txd_b, txd_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    int          sel;
    logic        obs_txd, obs_busy, obs_done, obs_ready;

    int n_chk  = 0;
    int n_pass = 0;

    logic cap_txd [1024];
    logic cap_busy[1024];
    logic cap_done[1024];
    logic cap_rdy [1024];

    always #5 clk = ~clk;

    uart_word_tx #(.CLKS_PER_BIT(4), .WORD_W(32), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst), .s_valid(valid_a), .s_ready(ready_a), .s_data(s_data),
        .txd(txd_a), .busy(busy_a), .done(done_a));

    uart_word_tx #(.CLKS_PER_BIT(4), .WORD_W(14), .DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .s_valid(valid_b), .s_ready(ready_b), .s_data(s_data[13:0]),
        .txd(txd_b), .busy(busy_b), .done(done_b));

    uart_word_tx #(.CLKS_PER_BIT(4), .WORD_W(32), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .rst(rst), .s_valid(valid_c), .s_ready(ready_c), .s_data(s_data),
        .txd(txd_c), .busy(busy_c), .done(done_c));

    // Route the selected instance to the observation signals
    always_comb begin
        case (sel)
            1:       begin obs_txd = txd_b; obs_busy = busy_b; obs_done = done_b; obs_ready = ready_b; end
            2:       begin obs_txd = txd_c; obs_busy = busy_c; obs_done = done_c; obs_ready = ready_c; end
            default: begin obs_txd = txd_a; obs_busy = busy_a; obs_done = done_a; obs_ready = ready_a; end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive_valid(input int s, input logic v);
        valid_a = (s == 0) ? v : 1'b0;
        valid_b = (s == 1) ? v : 1'b0;
        valid_c = (s == 2) ? v : 1'b0;
    endtask

    function automatic int frame_len(input vec_t v);
        return (1 + v.dbits + PAR_EN + v.sbits) * C;
    endfunction

    // Expected line level idx cycles after the handshake, from the hand-computed bytes
    function automatic logic exp_txd(input vec_t v, input int idx);
        int fr, f, b;
        logic [8:0] by;
        fr = frame_len(v);
        f  = idx / fr;
        b  = (idx % fr) / C;
        by = v.exp_byte[f];
        if (b == 0) return 1'b0;
        if (b <= v.dbits) return by[b-1];
        if (PAR_EN == 1 && b == v.dbits + 1) return v.exp_par[f];
        return 1'b1;
    endfunction

    task automatic sample(input int i);
        cap_txd[i]  = obs_txd;
        cap_busy[i] = obs_busy;
        cap_done[i] = obs_done;
        cap_rdy[i]  = obs_ready;
    endtask

    // Compare a captured word starting at base against the expected frames
    task automatic check_word(input vec_t v, input int base, input string tag);
        int fr, mism;
        logic [8:0] got;
        logic [8:0] eb;
        fr = frame_len(v);
        for (int f = 0; f < v.nbytes; f++) begin
            mism = 0;
            for (int j = 0; j < fr; j++)
                if (cap_txd[base + f*fr + j] !== exp_txd(v, f*fr + j)) mism++;
            check($sformatf("%s frame%0d wave_mismatches", tag, f), 32'(mism), 32'd0);
            got = '0;
            for (int i = 0; i < v.dbits; i++)
                got[i] = cap_txd[base + f*fr + (1 + i)*C + C/2];
            eb = v.exp_byte[f];
            check($sformatf("%s byte%0d", tag, f), 32'(got), 32'(eb));
            if (PAR_EN == 1)
                check($sformatf("%s parity%0d", tag, f),
                      32'(cap_txd[base + f*fr + (1 + v.dbits)*C + C/2]), 32'(v.exp_par[f]));
        end
    endtask

    // Send one word with a single-cycle valid and check the whole transfer
    task automatic run_vec(input vec_t v, input string tag);
        int fr, total, nbusy, ndone, done_at;
        fr    = frame_len(v);
        total = v.nbytes * fr;
        sel   = v.sel;
        @(negedge clk);
        check({tag, " ready_idle"}, 32'(obs_ready), 32'd1);
        drive_valid(v.sel, 1'b1);
        s_data = v.word;
        @(negedge clk);
        drive_valid(v.sel, 1'b0);
        s_data = ~v.word;
        for (int i = 0; i < total + 2; i++) begin
            sample(i);
            @(negedge clk);
        end
        check_word(v, 0, tag);
        nbusy = 0; ndone = 0; done_at = -1;
        for (int i = 0; i < total + 2; i++) begin
            if (cap_busy[i] === 1'b1) nbusy++;
            if (cap_done[i] === 1'b1) begin ndone++; done_at = i; end
        end
        check({tag, " busy_cycles"}, 32'(nbusy), 32'(total));
        check({tag, " done_pulses"}, 32'(ndone), 32'd1);
        check({tag, " done_at"}, 32'(done_at), 32'(total));
        check({tag, " txd_idle_after"}, 32'(cap_txd[total]), 32'd1);
    endtask

    vec_t vt[4];
    int   nvec;

    initial begin
        vec_t v0, v1, v2;
        int fr, total, idx_rst, ndone;

        rst = 1'b1;
        s_data = '0;
        valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
        sel = 0;

        vt[0] = '{sel: 0, word: 32'hA5C30F81, nbytes: 4, dbits: 8, sbits: 1,
                  exp_byte: {9'h0A5, 9'h0C3, 9'h00F, 9'h081}, exp_par: 4'b0000};
        vt[1] = '{sel: 0, word: 32'h00000081, nbytes: 4, dbits: 8, sbits: 1,
                  exp_byte: {9'h000, 9'h000, 9'h000, 9'h081}, exp_par: 4'b0000};
        vt[2] = '{sel: 1, word: 32'h00003F81, nbytes: 2, dbits: 7, sbits: 2,
                  exp_byte: {9'h000, 9'h000, 9'h07F, 9'h001}, exp_par: 4'b0011};
        vt[3] = '{sel: 2, word: 32'h00000081, nbytes: 4, dbits: 8, sbits: 1,
                  exp_byte: {9'h000, 9'h000, 9'h000, 9'h081}, exp_par: 4'b1111};
        nvec = (PAR_EN == 1) ? 4 : 3;

        // Reset held for three cycles with s_valid low
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset txd c%0d", i), 32'(txd_a), 32'd1);
            check($sformatf("reset busy c%0d", i), 32'(busy_a), 32'd0);
            check($sformatf("reset done c%0d", i), 32'(done_a), 32'd0);
            check($sformatf("reset ready c%0d", i), 32'(ready_a), 32'd1);
        end
        rst = 1'b0;

        for (int k = 0; k < nvec; k++)
            run_vec(vt[k], $sformatf("vec%0d", k));

        // Back-to-back words with s_valid held; s_data changes mid-word
        v0 = '{sel: 0, word: 32'h00000000, nbytes: 4, dbits: 8, sbits: 1,
               exp_byte: {9'h000, 9'h000, 9'h000, 9'h000}, exp_par: 4'b0000};
        v1 = '{sel: 0, word: 32'hFFFFFFFF, nbytes: 4, dbits: 8, sbits: 1,
               exp_byte: {9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF}, exp_par: 4'b0000};
        fr = frame_len(v0);
        total = 4 * fr;
        sel = 0;
        @(negedge clk);
        drive_valid(0, 1'b1);
        s_data = 32'h00000000;
        @(negedge clk);
        for (int i = 0; i < 2*total + 3; i++) begin
            sample(i);
            if (i == 50)  s_data = 32'h5A5A5A5A;
            if (i == 100) s_data = 32'hFFFFFFFF;
            if (i == total + 1) drive_valid(0, 1'b0);
            @(negedge clk);
        end
        check_word(v0, 0, "b2b w0");
        check("b2b gap txd", 32'(cap_txd[total]), 32'd1);
        check("b2b gap done", 32'(cap_done[total]), 32'd1);
        check("b2b gap ready", 32'(cap_rdy[total]), 32'd1);
        check("b2b gap busy", 32'(cap_busy[total]), 32'd0);
        check("b2b w1 start", 32'(cap_txd[total+1]), 32'd0);
        check("b2b w1 busy", 32'(cap_busy[total+1]), 32'd1);
        check_word(v1, total + 1, "b2b w1");
        ndone = 0;
        for (int i = 0; i < 2*total + 3; i++) if (cap_done[i] === 1'b1) ndone++;
        check("b2b done_pulses", 32'(ndone), 32'd2);
        check("b2b w1 done", 32'(cap_done[2*total+1]), 32'd1);

        // Reset in the middle of data bit 3 of byte 2 (0xC3 bit 3 is 0)
        idx_rst = 2*fr + 4*C + 1;
        @(negedge clk);
        drive_valid(0, 1'b1);
        s_data = 32'hA5C30F81;
        @(negedge clk);
        drive_valid(0, 1'b0);
        repeat (idx_rst) @(negedge clk);
        check("midrst txd_before", 32'(txd_a), 32'd0);
        check("midrst busy_before", 32'(busy_a), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst txd", 32'(txd_a), 32'd1);
        check("midrst busy", 32'(busy_a), 32'd0);
        check("midrst done", 32'(done_a), 32'd0);
        check("midrst ready", 32'(ready_a), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        v2 = '{sel: 0, word: 32'h12345678, nbytes: 4, dbits: 8, sbits: 1,
               exp_byte: {9'h012, 9'h034, 9'h056, 9'h078}, exp_par: 4'b0100};
        run_vec(v2, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
